// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic note-to-voice allocator that feeds the per-voice
// ADSR envelope generators. It assigns note-on events to voices, drives
// gate/note/velocity for each voice, and steals the oldest voice when all are busy.
// Optional sustain pedal support is enabled by defining VOICE_ALLOC_SUSTAIN_PEDAL_EN.
module voice_allocator #(
    parameter int unsigned VOICES    = 4,
    parameter int unsigned NOTE_BITS = 7,
    parameter int unsigned VEL_BITS  = 7,
    parameter int unsigned AGE_BITS  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ev_valid,
    output logic                        ev_ready,
    input  logic                        ev_on,
    input  logic [NOTE_BITS-1:0]        ev_note,
    input  logic [VEL_BITS-1:0]         ev_velocity,
    input  logic [VOICES-1:0]           voice_active,
`ifdef VOICE_ALLOC_SUSTAIN_PEDAL_EN
    input  logic                        sustain_pedal,
`endif
    output logic [VOICES-1:0]           gate,
    output logic [VOICES*NOTE_BITS-1:0] note,
    output logic [VOICES*VEL_BITS-1:0]  velocity
);

    localparam int unsigned IDX_W = (VOICES > 1) ? $clog2(VOICES) : 1;

    typedef enum logic {
        ST_READY,
        ST_GAP
    } state_t;

    state_t                           state_q, state_d;
    logic [VOICES-1:0]                gate_q, gate_d;
    logic [VOICES-1:0][NOTE_BITS-1:0] note_q, note_d;
    logic [VOICES-1:0][VEL_BITS-1:0]  vel_q, vel_d;
    logic [VOICES-1:0][AGE_BITS-1:0]  age_q, age_d;
    logic [IDX_W-1:0]                 gap_voice_q, gap_voice_d;
`ifdef VOICE_ALLOC_SUSTAIN_PEDAL_EN
    logic [VOICES-1:0]                held_q, held_d;
    logic                             pedal_q, pedal_d;
`endif

    logic             accept;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_gap;

    // Candidate search for each selection rule, resolved in priority order
    logic             retrig_hit, free_hit, rel_hit;
    logic [IDX_W-1:0] retrig_idx, free_idx, rel_idx, steal_idx;
    logic [AGE_BITS-1:0] rel_age, steal_age;

    assign ev_ready = (state_q == ST_READY);
    assign accept   = ev_valid && ev_ready;
    assign gate     = gate_q;
    assign note     = note_q;
    assign velocity = vel_q;

    // Note-on voice selection: retrigger, free, oldest releasing, oldest gated
    always_comb begin
        retrig_hit = 1'b0;
        retrig_idx = '0;
        free_hit   = 1'b0;
        free_idx   = '0;
        rel_hit    = 1'b0;
        rel_idx    = '0;
        rel_age    = '0;
        steal_idx  = '0;
        steal_age  = '0;
        for (int unsigned v = 0; v < VOICES; v++) begin
            if (!retrig_hit && gate_q[v] && (note_q[v] == ev_note)) begin
                retrig_hit = 1'b1;
                retrig_idx = IDX_W'(v);
            end
            if (!free_hit && !gate_q[v] && !voice_active[v]) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(v);
            end
            // strict compare keeps the lowest index on equal ages
            if (!gate_q[v] && voice_active[v] && (!rel_hit || (age_q[v] > rel_age))) begin
                rel_hit = 1'b1;
                rel_idx = IDX_W'(v);
                rel_age = age_q[v];
            end
            if ((v == 0) || (age_q[v] > steal_age)) begin
                steal_idx = IDX_W'(v);
                steal_age = age_q[v];
            end
        end

        if (retrig_hit) begin
            sel_idx = retrig_idx;
            sel_gap = 1'b1;
        end else if (free_hit) begin
            sel_idx = free_idx;
            sel_gap = 1'b0;
        end else if (rel_hit) begin
            sel_idx = rel_idx;
            sel_gap = 1'b0;
        end else begin
            sel_idx = steal_idx;
            sel_gap = 1'b1;
        end
    end

    // Next-state: pedal release, gap completion, then the accepted event
    always_comb begin
        state_d     = state_q;
        gate_d      = gate_q;
        note_d      = note_q;
        vel_d       = vel_q;
        age_d       = age_q;
        gap_voice_d = gap_voice_q;
`ifdef VOICE_ALLOC_SUSTAIN_PEDAL_EN
        held_d  = held_q;
        pedal_d = sustain_pedal;
        // pedal release is applied first so that an event on the same edge overrides it
        if (pedal_q && !sustain_pedal) begin
            gate_d = gate_d & ~held_q;
            held_d = '0;
        end
`endif
        if (state_q == ST_GAP) begin
            gate_d[gap_voice_q] = 1'b1;
            state_d             = ST_READY;
        end else if (accept) begin
            if (ev_on) begin
                note_d[sel_idx] = ev_note;
                vel_d[sel_idx]  = ev_velocity;
                for (int unsigned v = 0; v < VOICES; v++) begin
                    if (IDX_W'(v) == sel_idx) begin
                        age_d[v] = '0;
                    end else if (age_q[v] != '1) begin
                        age_d[v] = age_q[v] + AGE_BITS'(1);
                    end
                end
`ifdef VOICE_ALLOC_SUSTAIN_PEDAL_EN
                held_d[sel_idx] = 1'b0;
`endif
                if (sel_gap) begin
                    gate_d[sel_idx] = 1'b0;
                    gap_voice_d     = sel_idx;
                    state_d         = ST_GAP;
                end else begin
                    gate_d[sel_idx] = 1'b1;
                end
            end else begin
                for (int unsigned v = 0; v < VOICES; v++) begin
                    if (gate_q[v] && (note_q[v] == ev_note)) begin
`ifdef VOICE_ALLOC_SUSTAIN_PEDAL_EN
                        if (sustain_pedal) begin
                            held_d[v] = 1'b1;
                        end else begin
                            gate_d[v] = 1'b0;
                        end
`else
                        gate_d[v] = 1'b0;
`endif
                    end
                end
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_READY;
            gate_q      <= '0;
            note_q      <= '0;
            vel_q       <= '0;
            age_q       <= '0;
            gap_voice_q <= '0;
`ifdef VOICE_ALLOC_SUSTAIN_PEDAL_EN
            held_q      <= '0;
            pedal_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gate_q      <= gate_d;
            note_q      <= note_d;
            vel_q       <= vel_d;
            age_q       <= age_d;
            gap_voice_q <= gap_voice_d;
`ifdef VOICE_ALLOC_SUSTAIN_PEDAL_EN
            held_q      <= held_d;
            pedal_q     <= pedal_d;
`endif
        end
    end

endmodule
